// File: rtl/probe_tx_scheduler_pkg.sv
// Probe TX scheduler shared definitions.
// FSM states, default frame header constants and field offsets.
package probe_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    REQ,
    SEND,
    GAP
  } state_t;

  localparam logic [47:0] DEF_SRC_MAC   = 48'h004e46324300;
  localparam logic [47:0] DEF_DST_MAC   = 48'hFFFFFFFFFFFF;
  localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;

  localparam int OFS_SEQ = 14;
  localparam int OFS_TS  = 18;
  localparam int OFS_PAD = 22;

  localparam int IDX_W = 11;

endpackage

// File: rtl/probe_byte_mux.sv
// Probe frame byte selector.
// Maps a byte index to header, sequence, timestamp or pad data.
module probe_byte_mux
  import probe_tx_scheduler_pkg::*;
#(
  parameter logic [47:0] SRC_MAC   = DEF_SRC_MAC,
  parameter logic [47:0] DST_MAC   = DEF_DST_MAC,
  parameter logic [15:0] ETHERTYPE = DEF_ETHERTYPE
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      seq,
  input  logic [31:0]      ts,
  output logic [7:0]       data
);

  int i;

  // Select the byte for the current index, MSB first per field.
  always_comb begin
    data = 8'h00;
    i = int'(idx);
    unique case (1'b1)
      i inside {[0:5]}:
        data = DST_MAC[8*(5-i) +: 8];
      i inside {[6:11]}:
        data = SRC_MAC[8*(11-i) +: 8];
      i inside {[12:OFS_SEQ-1]}:
        data = ETHERTYPE[8*(OFS_SEQ-1-i) +: 8];
      i inside {[OFS_SEQ:OFS_TS-1]}:
        data = seq[8*(OFS_TS-1-i) +: 8];
      i inside {[OFS_TS:OFS_PAD-1]}:
        data = ts[8*(OFS_PAD-1-i) +: 8];
      default:
        data = 8'h00;
    endcase
  end

endmodule

// File: rtl/probe_tx_scheduler.sv
// Periodic probe frame scheduler feeding a byte-wide MAC.
// Sequences header, seq number and tx timestamp with paced gaps.
module probe_tx_scheduler
  import probe_tx_scheduler_pkg::*;
#(
  parameter logic [47:0] SRC_MAC   = DEF_SRC_MAC,
  parameter logic [47:0] DST_MAC   = DEF_DST_MAC,
  parameter logic [15:0] ETHERTYPE = DEF_ETHERTYPE,
  parameter int          FRAME_LEN = 60,
  parameter int          MIN_GAP   = 12,
  parameter logic [31:0] TS_INIT   = 32'h0
) (
  input  logic        tx_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] interval,
  input  logic [15:0] frame_limit,
  output logic        conf_tx_en,
  output logic        conf_tx_jumbo_en,
  output logic        conf_tx_no_gen_crc,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_dvld,
  input  logic        mac_tx_ack,
  output logic [31:0] seq_num,
  output logic [31:0] timestamp,
  output logic        busy
);

  state_t state, state_nx;

  logic [IDX_W-1:0] idx;
  logic [31:0]      per;
  logic [15:0]      gap_cnt;
  logic [31:0]      ts_lat;
  logic [15:0]      sent;
  logic             en_q;
  logic             fresh;
  logic [7:0]       mux_data;

  logic        rise;
  logic [15:0] sent_eff;
  logic        limit_hit;
  logic        can_go;
  logic        per_zero;
  logic        last_byte;
  logic        gap_done;
  logic        start;

  assign rise      = enable & ~en_q;
  assign sent_eff  = rise ? 16'd0 : sent;
  assign limit_hit = (frame_limit != 16'd0) &&
                     (sent_eff >= frame_limit);
  assign can_go    = enable & ~limit_hit;
  assign per_zero  = (per == 32'd0);
  assign last_byte = (idx == IDX_W'(FRAME_LEN-1));
  assign gap_done  = (gap_cnt == 16'(MIN_GAP-1));
  assign start     = (state_nx == REQ) && (state != REQ);

  assign conf_tx_jumbo_en   = 1'b0;
  assign conf_tx_no_gen_crc = 1'b0;
  assign busy               = mac_tx_dvld;
  assign mac_tx_data        = mac_tx_dvld ? mux_data : 8'h00;

  // Next-state decode for frame pacing.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (can_go) state_nx = REQ;
      WAIT: begin
        if (!can_go)       state_nx = IDLE;
        else if (per_zero) state_nx = REQ;
      end
      REQ:  if (mac_tx_ack) state_nx = SEND;
      SEND: if (last_byte)  state_nx = GAP;
      GAP: begin
        if (gap_done) begin
          if (!can_go)       state_nx = IDLE;
          else if (per_zero) state_nx = REQ;
          else               state_nx = WAIT;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counters and per-frame latches.
  always_ff @(posedge tx_clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      per         <= 32'd0;
      gap_cnt     <= 16'd0;
      ts_lat      <= 32'd0;
      seq_num     <= 32'd0;
      sent        <= 16'd0;
      en_q        <= 1'b0;
      fresh       <= 1'b1;
      timestamp   <= TS_INIT;
      conf_tx_en  <= 1'b0;
      mac_tx_dvld <= 1'b0;
    end else begin
      state       <= state_nx;
      conf_tx_en  <= 1'b1;
      timestamp   <= timestamp + 32'd1;
      en_q        <= enable;
      mac_tx_dvld <= (state_nx == REQ) ||
                     (state_nx == SEND);
      gap_cnt     <= (state == GAP) ?
                     gap_cnt + 16'd1 : 16'd0;

      if (start)
        per <= per_zero_load(interval);
      else if (!per_zero)
        per <= per - 32'd1;

      if (rise) begin
        sent  <= 16'd0;
        fresh <= 1'b1;
      end

      if (start) begin
        seq_num <= (fresh | rise) ?
                   32'd0 : seq_num + 32'd1;
        fresh   <= 1'b0;
        sent    <= sent_eff + 16'd1;
        ts_lat  <= timestamp + 32'd1;
        idx     <= '0;
      end else if (state == REQ && mac_tx_ack) begin
        idx <= IDX_W'(1);
      end else if (state == SEND && !last_byte) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  function automatic logic [31:0] per_zero_load(
    input logic [31:0] ivl
  );
    return (ivl == 32'd0) ? 32'd0 : ivl - 32'd1;
  endfunction

  probe_byte_mux #(
    .SRC_MAC   (SRC_MAC),
    .DST_MAC   (DST_MAC),
    .ETHERTYPE (ETHERTYPE)
  ) u_mux (
    .idx  (idx),
    .seq  (seq_num),
    .ts   (ts_lat),
    .data (mux_data)
  );

endmodule
